branch_ctrl: RTL

//  Sequences branch resolution in ID: takes 3-bit branchcontrol code, waits for forwarded operands,

---
 rtl/branch_ctrl_pkg.sv | 18 +
 rtl/branch_ctrl_if.sv | 32 +++
 rtl/branch_cmp.sv | 32 +++
 rtl/branch_ctrl.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/branch_ctrl_pkg.sv
// Shared branch condition codes and FSM state encoding for the branch resolution block.
package branch_ctrl_pkg;

  localparam logic [2:0] BRANCH_NONE = 3'b000;
  localparam logic [2:0] BRANCH_EQ   = 3'b001;
  localparam logic [2:0] BRANCH_NEQ  = 3'b010;
  localparam logic [2:0] BRANCH_GTZ  = 3'b011;
  localparam logic [2:0] BRANCH_LEZ  = 3'b100;
  localparam logic [2:0] BRANCH_GEZ  = 3'b101;
  localparam logic [2:0] BRANCH_LTZ  = 3'b110;

  typedef enum logic [1:0] {
    BRCTL_IDLE     = 2'b00,
    BRCTL_WAIT     = 2'b01,
    BRCTL_REDIRECT = 2'b10
  } brctl_state_t;

endpackage

// File: rtl/branch_ctrl_if.sv
// ID-stage branch request plus IF redirect valid/ready channel; master drives ID inputs, slave is branch_ctrl.
interface branch_ctrl_if #(parameter int WIDTH = 32);

  logic             id_valid;
  logic [2:0]       branchcontrol;
  logic             id_link;
  logic [WIDTH-1:0] id_pc;
  logic [WIDTH-1:0] id_offset;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic             opnd_ready;
  logic             redirect_ready;
  logic             stall_id;
  logic             redirect_valid;
  logic [WIDTH-1:0] redirect_pc;
  logic             link_we;
  logic [WIDTH-1:0] link_pc;
  logic             hazard_err;

  modport master (
    output id_valid, branchcontrol, id_link, id_pc, id_offset, srca, srcb, opnd_ready,
           redirect_ready,
    input  stall_id, redirect_valid, redirect_pc, link_we, link_pc, hazard_err
  );

  modport slave (
    input  id_valid, branchcontrol, id_link, id_pc, id_offset, srca, srcb, opnd_ready,
           redirect_ready,
    output stall_id, redirect_valid, redirect_pc, link_we, link_pc, hazard_err
  );

endinterface

// File: rtl/branch_cmp.sv
// Combinational branch condition evaluator: signed compares of rs/rt; unknown nonzero codes are not taken.
module branch_cmp
  import branch_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       code,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic             taken
);

  logic neg;
  logic zero;

  assign neg  = srca[WIDTH-1];
  assign zero = (srca == '0);

  always_comb begin
    taken = 1'b0;
    case (code)
      BRANCH_EQ:  taken = (srca == srcb);
      BRANCH_NEQ: taken = (srca != srcb);
      BRANCH_GTZ: taken = !neg && !zero;
      BRANCH_LEZ: taken = neg || zero;
      BRANCH_GEZ: taken = !neg;
      BRANCH_LTZ: taken = neg;
      default:    taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_ctrl.sv
// Branch resolution FSM: resolve->redirect_valid 1 cycle; redirect held until redirect_ready, stall_id backpressures ID.
// Optional BRANCH_STATS_EN adds branch/taken/stall-cycle counters.
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  branch_ctrl_if.slave bus
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_taken,
  output logic [31:0] stat_stall_cycles
`endif
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  brctl_state_t     state;
  logic [CW-1:0]    wait_cnt;
  logic             br;
  logic             taken;
  logic             resolve;
  logic             timeout;
  logic             stall;
  logic [WIDTH-1:0] target;

  assign br      = bus.id_valid && (bus.branchcontrol != BRANCH_NONE);
  assign target  = bus.id_pc + WIDTH'(4) + (bus.id_offset << 2);
  assign timeout = (state == BRCTL_WAIT) && br && !bus.opnd_ready &&
                   (wait_cnt == CW'(MAX_WAIT));

  branch_cmp #(.WIDTH(WIDTH)) u_cmp (
    .code  (bus.branchcontrol),
    .srca  (bus.srca),
    .srcb  (bus.srcb),
    .taken (taken)
  );

  // A branch behind a pending redirect resolves only in the cycle the old redirect is accepted.
  always_comb begin
    resolve = 1'b0;
    stall   = 1'b0;
    case (state)
      BRCTL_IDLE, BRCTL_WAIT: begin
        resolve = br && bus.opnd_ready;
        stall   = br && !bus.opnd_ready && !timeout;
      end
      BRCTL_REDIRECT: begin
        resolve = br && bus.opnd_ready && bus.redirect_ready;
        stall   = br && !(bus.opnd_ready && bus.redirect_ready);
      end
      default: begin
        resolve = 1'b0;
        stall   = 1'b0;
      end
    endcase
  end

  assign bus.stall_id = stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= BRCTL_IDLE;
      wait_cnt           <= '0;
      bus.redirect_valid <= 1'b0;
      bus.redirect_pc    <= '0;
      bus.link_we        <= 1'b0;
      bus.link_pc        <= '0;
      bus.hazard_err     <= 1'b0;
    end else begin
      bus.link_we <= resolve && bus.id_link;
      if (resolve && bus.id_link) begin
        bus.link_pc <= bus.id_pc + WIDTH'(8);
      end

      if (resolve) begin
        wait_cnt <= '0;
        if (taken) begin
          state              <= BRCTL_REDIRECT;
          bus.redirect_valid <= 1'b1;
          bus.redirect_pc    <= target;
        end else begin
          state              <= BRCTL_IDLE;
          bus.redirect_valid <= 1'b0;
        end
      end else begin
        case (state)
          BRCTL_IDLE: begin
            if (br) begin
              state    <= BRCTL_WAIT;
              wait_cnt <= CW'(1);
            end
          end
          BRCTL_WAIT: begin
            if (!br) begin
              state    <= BRCTL_IDLE;
              wait_cnt <= '0;
            end else if (timeout) begin
              state          <= BRCTL_IDLE;
              wait_cnt       <= '0;
              bus.hazard_err <= 1'b1;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
          BRCTL_REDIRECT: begin
            if (bus.redirect_ready) begin
              bus.redirect_valid <= 1'b0;
              if (br) begin
                state    <= BRCTL_WAIT;
                wait_cnt <= CW'(1);
              end else begin
                state <= BRCTL_IDLE;
              end
            end
          end
          default: begin
            state              <= BRCTL_IDLE;
            bus.redirect_valid <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_branches     <= '0;
      stat_taken        <= '0;
      stat_stall_cycles <= '0;
    end else begin
      stat_branches     <= stat_branches + {31'd0, resolve};
      stat_taken        <= stat_taken + {31'd0, resolve && taken};
      stat_stall_cycles <= stat_stall_cycles + {31'd0, stall};
    end
  end
`endif

endmodule
